memory_stage: RTL

//  M stage of the 5-stage MIPS pipeline, downstream of execute. Latches the X/M pipeline

---
 rtl/memory_stage.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// memory_stage: M stage of the 5-stage MIPS pipeline.
// Holds the X/M pipeline register and runs LW/LB/LBU/SW/SB on a req/ack data-memory
// port that can take any number of cycles. The pipeline stalls while an access is
// outstanding, and an access that gets no ack within TIMEOUT cycles is abandoned.
// Optional feature: define MEM_ALIGN_CHECK_EN to trap misaligned word accesses
// (adds the sticky align_err output).
module memory_stage #(
    parameter int TIMEOUT = 64,  // max WAIT cycles before an access is abandoned (>=1)
    parameter int CNT_W   = 7    // wait-counter width, must hold TIMEOUT
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        x_valid,
    input  logic [31:0] x_aluout,
    input  logic [31:0] x_rb,
    input  logic        x_dmwe,
    input  logic        x_dmre,
    input  logic        x_dm_byte,
    input  logic        x_unsigned,
    input  logic        x_rwe,
    input  logic        x_rwd,
    input  logic [4:0]  x_wreg,
    output logic        stall,
    output logic [31:0] mx_bypass,
    output logic [4:0]  m_wreg,
    output logic        m_rwe,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        wb_valid,
    output logic        wb_rwe,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        bus_err
`ifdef MEM_ALIGN_CHECK_EN
    , output logic      align_err
`endif
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    // X/M pipeline register fields (m_wreg / m_rwe are ports)
    logic        m_valid;
    logic [31:0] m_aluout;
    logic [31:0] m_rb;
    logic        m_dmwe;
    logic        m_dmre;
    logic        m_dm_byte;
    logic        m_unsigned;
    logic        m_rwd;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             done_flag;
    logic             misalign;
    logic             mem;
    logic             timeout_hit;
    logic             access_end;
    logic [1:0]       lane;
    logic [7:0]       rbyte;
    logic [31:0]      load_data;
    logic [31:0]      wb_data_nx;

    assign lane = m_aluout[1:0];

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = m_valid & (m_dmwe | m_dmre) & ~m_dm_byte & (lane != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Request and stall generation; a misaligned word access never reaches the bus.
    assign mem         = m_valid & (m_dmwe | m_dmre) & ~misalign;
    assign dm_req      = mem & ~done_flag;
    assign timeout_hit = dm_req & (state == S_WAIT) & (cnt == CNT_W'(TIMEOUT - 1)) & ~dm_ack;
    assign stall       = dm_req & ~dm_ack & ~timeout_hit;
    assign access_end  = dm_req & (dm_ack | timeout_hit);

    // Bus side is driven straight from the M register, so it is stable for the whole access.
    assign mx_bypass = m_aluout;
    assign dm_addr   = {m_aluout[31:2], 2'b00};
    assign dm_we     = dm_req & m_dmwe;
    assign dm_be     = !dm_req   ? 4'b0000 :
                       m_dm_byte ? (4'b1000 >> lane) : 4'b1111;
    assign dm_wdata  = m_dm_byte ? {4{m_rb[7:0]}} : m_rb;

    // X/M register: advances whenever the stage is not stalled.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            m_valid    <= 1'b0;
            m_aluout   <= '0;
            m_rb       <= '0;
            m_dmwe     <= 1'b0;
            m_dmre     <= 1'b0;
            m_dm_byte  <= 1'b0;
            m_unsigned <= 1'b0;
            m_rwe      <= 1'b0;
            m_rwd      <= 1'b0;
            m_wreg     <= '0;
        end else if (!stall) begin
            m_valid    <= x_valid;
            m_aluout   <= x_aluout;
            m_rb       <= x_rb;
            m_dmwe     <= x_dmwe;
            m_dmre     <= x_dmre;
            m_dm_byte  <= x_dm_byte;
            m_unsigned <= x_unsigned;
            m_rwe      <= x_rwe;
            m_rwd      <= x_rwd;
            m_wreg     <= x_wreg;
        end
    end

    // Access-completed marker: keeps an instruction that lingers in M from re-issuing.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done_flag <= 1'b0;
        end else if (!stall) begin
            done_flag <= 1'b0;
        end else if (access_end) begin
            done_flag <= 1'b1;
        end
    end

    // Wait FSM next state: IDLE until a request misses its first-cycle ack, WAIT until ack or timeout.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_IDLE: begin
                if (dm_req && !dm_ack) begin
                    state_nx = S_WAIT;
                    cnt_nx   = '0;
                end
            end
            S_WAIT: begin
                if (!dm_req || dm_ack || timeout_hit) begin
                    state_nx = S_IDLE;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Wait FSM state and counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Big-endian byte lane select: address 0 is bits 31:24.
    always_comb begin
        rbyte = dm_rdata[31:24];
        case (lane)
            2'd0: rbyte = dm_rdata[31:24];
            2'd1: rbyte = dm_rdata[23:16];
            2'd2: rbyte = dm_rdata[15:8];
            2'd3: rbyte = dm_rdata[7:0];
            default: rbyte = dm_rdata[31:24];
        endcase
    end

    // Load data formatting; an abandoned access reads as zero.
    always_comb begin
        load_data = dm_rdata;
        if (timeout_hit) begin
            load_data = '0;
        end else if (m_dm_byte) begin
            load_data = m_unsigned ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
        end
        wb_data_nx = misalign ? 32'b0 : (m_rwd ? load_data : m_aluout);
    end

    // M/W register: loads the finished instruction, or a bubble while stalled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid <= 1'b0;
            wb_rwe   <= 1'b0;
            wb_reg   <= '0;
            wb_data  <= '0;
        end else if (!stall) begin
            wb_valid <= m_valid;
            wb_rwe   <= m_valid & m_rwe & ~misalign;
            wb_reg   <= m_wreg;
            wb_data  <= wb_data_nx;
        end else begin
            wb_valid <= 1'b0;
            wb_rwe   <= 1'b0;
        end
    end

    // Sticky bus error: set when an access is abandoned, cleared only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus_err <= 1'b0;
        end else if (timeout_hit) begin
            bus_err <= 1'b1;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    // Sticky alignment error for word accesses with nonzero low address bits.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            align_err <= 1'b0;
        end else if (misalign) begin
            align_err <= 1'b1;
        end
    end
`endif

endmodule
